// File: rtl/pb_debounce_bank.sv
// pb_debounce_bank
//   N-channel push-button / slide-switch conditioner on the system clock.
//   Per channel: a flop synchroniser, a counter debouncer paced by the
//   sample_en strobe, registered press/release pulses and an optional
//   hold-to-repeat generator.
//
//   Strobe semantics: sample_en is a 1-clk qualifier, not a handshake. The
//   synchroniser runs every clk. The debounce and repeat counters only move
//   on clk edges where sample_en=1. All outputs are registered. The pulse
//   outputs are high for exactly one clk and line up with the pb_status edge.
//
//   Debug visibility: each channel's repeat FSM state and counter are
//   g_ch[i].g_rpt.rpt_state and g_ch[i].g_rpt.hold_cnt. The debounce counter
//   is g_ch[i].deb_cnt.
module pb_debounce_bank #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 20,
    parameter int REPEAT_EN     = 1,
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] pb_status,
    output logic [N_CH-1:0] pb_pressed,
    output logic [N_CH-1:0] pb_released,
    output logic [N_CH-1:0] pb_repeat
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = {HOLD_W{1'b1}};

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Parameter sanity: refuse to elaborate a configuration that cannot work.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("pb_debounce_bank: SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_chk_deb
        $error("pb_debounce_bank: DEB_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_rep
        $error("pb_debounce_bank: REPEAT_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < REPEAT_CYCLES) begin : g_chk_hold
        $error("pb_debounce_bank: HOLD_CYCLES must be >= REPEAT_CYCLES");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic [DEB_W-1:0]       deb_cnt;
        logic                   status_q;
        logic                   pressed_q;
        logic                   released_q;
        logic                   differ;
        logic                   flip;

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign differ   = (sync_out != status_q);
        // The sample that completes the run of differing samples.
        assign flip     = sample_en && differ && (deb_cnt == DEB_LAST);

        // Synchroniser chain: shifts every clk, independent of sample_en.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pb[i]};
            end
        end

        // Debounce counter and registered level and edge pulses.
        always_ff @(posedge clk) begin
            if (reset) begin
                deb_cnt    <= '0;
                status_q   <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                if (sample_en) begin
                    if (!differ) begin
                        deb_cnt <= '0;
                    end else if (flip) begin
                        deb_cnt    <= '0;
                        status_q   <= ~status_q;
                        pressed_q  <= ~status_q;
                        released_q <= status_q;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            end
        end

        assign pb_status[i]   = status_q;
        assign pb_pressed[i]  = pressed_q;
        assign pb_released[i] = released_q;

        if (REPEAT_EN != 0) begin : g_rpt
            rpt_state_t        rpt_state;
            logic [HOLD_W-1:0] hold_cnt;
            logic              repeat_q;

            // Hold-to-repeat FSM. Press and release events come from the same
            // edge that updates pb_status, so a release pre-empts any repeat
            // pulse that would otherwise fall in that cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rpt_state <= RPT_IDLE;
                    hold_cnt  <= '0;
                    repeat_q  <= 1'b0;
                end else begin
                    repeat_q <= 1'b0;
                    if (flip && status_q) begin
                        rpt_state <= RPT_IDLE;
                        hold_cnt  <= '0;
                    end else if (flip && !status_q) begin
                        rpt_state <= RPT_HOLD;
                        hold_cnt  <= '0;
                    end else if (sample_en) begin
                        case (rpt_state)
                            RPT_HOLD: begin
                                if (hold_cnt == HOLD_LAST) begin
                                    repeat_q  <= 1'b1;
                                    rpt_state <= RPT_REPEAT;
                                    hold_cnt  <= '0;
                                end else if (hold_cnt != HOLD_MAX) begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                            RPT_REPEAT: begin
                                if (hold_cnt == REPEAT_LAST) begin
                                    repeat_q <= 1'b1;
                                    hold_cnt <= '0;
                                end else if (hold_cnt != HOLD_MAX) begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                            default: begin
                                rpt_state <= RPT_IDLE;
                                hold_cnt  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign pb_repeat[i] = repeat_q;
        end else begin : g_no_rpt
            assign pb_repeat[i] = 1'b0;
        end
    end

endmodule
